// File: rtl/seg7_clock_if.sv
// Bundles the run/set/inc controls and the display/status outputs of seg7_clock_core.
// HOUR12_MODE_EN adds the pm flag.
interface seg7_clock_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    run;
  logic                    set_req;
  logic                    inc;
  logic [7*NUM_DIGITS-1:0] seg_export;
  logic                    tick_1hz;
  logic                    day_wrap;
  logic                    editing;
`ifdef HOUR12_MODE_EN
  logic                    pm;
`endif

  modport master (
    output run, set_req, inc,
`ifdef HOUR12_MODE_EN
    input  pm,
`endif
    input  seg_export, tick_1hz, day_wrap, editing
  );

  modport slave (
    input  run, set_req, inc,
`ifdef HOUR12_MODE_EN
    output pm,
`endif
    output seg_export, tick_1hz, day_wrap, editing
  );
endinterface

// File: rtl/seg7_clock_core.sv
// HH:MM[:SS] BCD real-time clock with set mode and blinking edit field, driving 7-segment digits.
// Optional HOUR12_MODE_EN: 12-hour counting (12,01..11) with a pm flag.
//
// state   | meaning
// S_RUN   | time advances on the 1 Hz tick
// S_SET_H | editing hours, prescaler held at 0
// S_SET_M | editing minutes, prescaler held at 0
// S_SET_S | inc clears seconds, prescaler held at 0
module seg7_clock_core #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_DIGITS  = 6,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  seg7_clock_if.slave bus
);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
    $error("seg7_clock_core: NUM_DIGITS must be 4 or 6");
  end
  if (CLK_FREQ_HZ < 4) begin : g_bad_freq
    $error("seg7_clock_core: CLK_FREQ_HZ must be at least 4");
  end

  localparam bit HAS_SEC = (NUM_DIGITS == 6);
  localparam int OFF     = HAS_SEC ? 0 : 2;
  localparam int PW      = $clog2(CLK_FREQ_HZ);
  localparam int BLINK_H = CLK_FREQ_HZ / 4;
  localparam int BW      = $clog2(BLINK_H) + 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ_HZ - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_H - 1);
`ifdef HOUR12_MODE_EN
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  typedef enum logic [1:0] {S_RUN, S_SET_H, S_SET_M, S_SET_S} state_t;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Digit slots 0..5 are s0,s1,m0,m1,h0,h1; a 4-digit build starts at m0.
  function automatic logic [7*NUM_DIGITS-1:0] render(input logic [7:0] h, input logic [7:0] m,
                                                     input logic [7:0] s, input logic [5:0] blank);
    logic [3:0]              d [6];
    logic [6:0]              g;
    logic [7*NUM_DIGITS-1:0] r;
    d[0] = s[3:0];
    d[1] = s[7:4];
    d[2] = m[3:0];
    d[3] = m[7:4];
    d[4] = h[3:0];
    d[5] = h[7:4];
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      g = blank[k+OFF] ? 7'h00 : enc(d[k+OFF]);
      r[7*k +: 7] = SEG_ACT_LOW ? ~g : g;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    return (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] hour_next(input logic [7:0] v);
`ifdef HOUR12_MODE_EN
    return (v == 8'h12) ? 8'h01 : bcd_inc(v);
`else
    return (v == 8'h23) ? 8'h00 : bcd_inc(v);
`endif
  endfunction

  localparam logic [7*NUM_DIGITS-1:0] SEG_RST = render(HR_RST, 8'h00, 8'h00, 6'b0);

  state_t                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_q, blink_d;
  logic [7:0]              hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic                    tick_q, tick_d, wrap_q, wrap_d, editing_q;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    running, tc;
  logic [5:0]              blank;
`ifdef HOUR12_MODE_EN
  logic                    pm_q, pm_d;
`endif

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef HOUR12_MODE_EN
    pm_d    = pm_q;
`endif
    running = (state_q == S_RUN) && bus.run;
    tc      = running && (presc_q == PRESC_TC);
    presc_d = (running && !tc) ? presc_q + PW'(1) : '0;

    if (tc) begin
      tick_d = 1'b1;
      if (HAS_SEC) sec_d = inc_mod60(sec_q);
      if (!HAS_SEC || sec_q == 8'h59) begin
        min_d = inc_mod60(min_q);
        if (min_q == 8'h59) begin
          hr_d = hour_next(hr_q);
`ifdef HOUR12_MODE_EN
          if (hr_q == 8'h11) begin
            pm_d   = ~pm_q;
            wrap_d = pm_q;
          end
`else
          wrap_d = (hr_q == 8'h23);
`endif
        end
      end
    end

    // set_req has priority; a coincident inc is dropped.
    if (bus.set_req) begin
      case (state_q)
        S_RUN:   state_d = S_SET_H;
        S_SET_H: state_d = S_SET_M;
        S_SET_M: state_d = HAS_SEC ? S_SET_S : S_RUN;
        default: state_d = S_RUN;
      endcase
    end else if (bus.inc) begin
      case (state_q)
        S_SET_H: begin
          hr_d = hour_next(hr_q);
`ifdef HOUR12_MODE_EN
          if (hr_q == 8'h11) pm_d = ~pm_q;
`endif
        end
        S_SET_M: min_d = inc_mod60(min_q);
        S_SET_S: sec_d = 8'h00;
        default: ;
      endcase
    end
    if (state_d != S_RUN) presc_d = '0;

    if (blink_cnt_q == '0) begin
      blink_cnt_d = BLINK_TC;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q - BW'(1);
      blink_d     = blink_q;
    end

    blank = 6'b0;
    if (blink_q) begin
      case (state_q)
        S_SET_H: blank = 6'b110000;
        S_SET_M: blank = 6'b001100;
        S_SET_S: blank = 6'b000011;
        default: blank = 6'b0;
      endcase
    end
    seg_d = render(hr_q, min_q, sec_q, blank);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_RUN;
      presc_q     <= '0;
      blink_cnt_q <= BLINK_TC;
      blink_q     <= 1'b0;
      hr_q        <= HR_RST;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      editing_q   <= 1'b0;
      seg_q       <= SEG_RST;
`ifdef HOUR12_MODE_EN
      pm_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      editing_q   <= (state_d != S_RUN);
      seg_q       <= seg_d;
`ifdef HOUR12_MODE_EN
      pm_q        <= pm_d;
`endif
    end
  end

  assign bus.seg_export = seg_q;
  assign bus.tick_1hz   = tick_q;
  assign bus.day_wrap   = wrap_q;
  assign bus.editing    = editing_q;
`ifdef HOUR12_MODE_EN
  assign bus.pm         = pm_q;
`endif

endmodule

// File: tb/tb_seg7_clock_core.sv
// Directed bench for seg7_clock_core (24-hour build, CLK_FREQ_HZ=8, six active-low digits).
module tb_seg7_clock_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seg7_clock_if #(.NUM_DIGITS(6)) bus ();

  seg7_clock_core #(.CLK_FREQ_HZ(8), .NUM_DIGITS(6), .SEG_ACT_LOW(1'b1)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [6:0]  G0    = 7'b1000000;
  localparam logic [6:0]  G1    = 7'b1111001;
  localparam logic [41:0] ZEROS = {6{7'b1000000}};

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] seg6(input int h1, input int h0, input int m1, input int m0,
                                       input int s1, input int s0);
    return {glyph(h1), glyph(h0), glyph(m1), glyph(m0), glyph(s1), glyph(s0)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_set();
    bus.set_req = 1'b1;
    cyc(1);
    bus.set_req = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.inc = 1'b1;
      cyc(1);
      bus.inc = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if (bus.seg_export !== ZEROS) begin
      errors++;
      $display("FAIL reset_seg got %b want %b", bus.seg_export, ZEROS);
    end
    checks++;
    if (bus.tick_1hz !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", bus.tick_1hz); end
    checks++;
    if (bus.day_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.day_wrap); end
    checks++;
    if (bus.editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %b want 0", bus.editing); end
  endtask

  task automatic test_tick();
    rst_n = 1'b1;
    cyc(7);
    checks++;
    if (bus.tick_1hz !== 1'b0) begin errors++; $display("FAIL tick_early got %b want 0", bus.tick_1hz); end
    cyc(1);
    checks++;
    if (bus.tick_1hz !== 1'b1) begin errors++; $display("FAIL tick_cycle8 got %b want 1", bus.tick_1hz); end
    checks++;
    if (bus.seg_export[6:0] !== G0) begin
      errors++;
      $display("FAIL tick_seg_latency got %b want %b", bus.seg_export[6:0], G0);
    end
    cyc(1);
    checks++;
    if (bus.tick_1hz !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", bus.tick_1hz); end
    checks++;
    if (bus.seg_export[6:0] !== G1) begin
      errors++;
      $display("FAIL tick_seg_one got %b want %b", bus.seg_export[6:0], G1);
    end
  endtask

  task automatic test_day_wrap();
    do_reset();
    pulse_set();
    pulse_inc(23);
    pulse_set();
    pulse_inc(59);
    pulse_set();
    pulse_set();
    cyc(464);
    cyc(1);
    checks++;
    if (bus.seg_export !== seg6(2, 3, 5, 9, 5, 8)) begin
      errors++;
      $display("FAIL wrap_235958 got %b want %b", bus.seg_export, seg6(2, 3, 5, 9, 5, 8));
    end
    cyc(7);
    checks++;
    if (bus.tick_1hz !== 1'b1 || bus.day_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_235959 tick/wrap got %b%b want 10", bus.tick_1hz, bus.day_wrap);
    end
    cyc(8);
    checks++;
    if (bus.tick_1hz !== 1'b1 || bus.day_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pulse tick/wrap got %b%b want 11", bus.tick_1hz, bus.day_wrap);
    end
    cyc(1);
    checks++;
    if (bus.day_wrap !== 1'b0) begin errors++; $display("FAIL wrap_width got %b want 0", bus.day_wrap); end
    checks++;
    if (bus.seg_export !== ZEROS) begin
      errors++;
      $display("FAIL wrap_000000 got %b want %b", bus.seg_export, ZEROS);
    end
  endtask

  task automatic test_set_hours();
    int ticks;
    int nblank;
    int none;
    logic [13:0] hh [4];
    do_reset();
    cyc(1);
    pulse_set();
    checks++;
    if (bus.editing !== 1'b1) begin errors++; $display("FAIL set_editing got %b want 1", bus.editing); end
    ticks = 0;
    for (int i = 0; i < 25; i++) begin
      bus.inc = 1'b1;
      cyc(1);
      ticks += int'(bus.tick_1hz);
      bus.inc = 1'b0;
      cyc(1);
      ticks += int'(bus.tick_1hz);
    end
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL set_no_ticks got %0d want 0", ticks); end
    nblank = 0;
    none = 0;
    for (int i = 0; i < 4; i++) begin
      hh[i] = bus.seg_export[41:28];
      if (hh[i] === 14'h3FFF) nblank++;
      if (hh[i] === {G0, G1}) none++;
      checks++;
      if (bus.seg_export[27:0] !== {4{G0}}) begin
        errors++;
        $display("FAIL set_other_digits got %b want %b", bus.seg_export[27:0], {4{G0}});
      end
      cyc(1);
    end
    checks++;
    if (nblank != 2 || none != 2) begin
      errors++;
      $display("FAIL set_hh_blink blank/shown got %0d/%0d want 2/2", nblank, none);
    end
    checks++;
    if (hh[0] === hh[2] || hh[1] === hh[3]) begin
      errors++;
      $display("FAIL set_hh_period got %b %b %b %b want 2-cycle alternation", hh[0], hh[1], hh[2], hh[3]);
    end
  endtask

  task automatic test_set_inc_collide();
    pulse_set();
    pulse_inc(7);
    bus.set_req = 1'b1;
    bus.inc     = 1'b1;
    cyc(1);
    bus.set_req = 1'b0;
    bus.inc     = 1'b0;
    cyc(1);
    checks++;
    if (bus.seg_export[27:14] !== {G0, glyph(7)}) begin
      errors++;
      $display("FAIL collide_mm got %b want %b", bus.seg_export[27:14], {G0, glyph(7)});
    end
    pulse_set();
    checks++;
    if (bus.editing !== 1'b0) begin errors++; $display("FAIL collide_state got %b want 0", bus.editing); end
    cyc(1);
    checks++;
    if (bus.seg_export !== seg6(0, 1, 0, 7, 0, 0)) begin
      errors++;
      $display("FAIL collide_time got %b want %b", bus.seg_export, seg6(0, 1, 0, 7, 0, 0));
    end
  endtask

  task automatic test_run_hold();
    int ticks;
    bus.run = 1'b0;
    do_reset();
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      ticks += int'(bus.tick_1hz);
    end
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL hold_ticks got %0d want 0", ticks); end
    checks++;
    if (bus.seg_export !== ZEROS) begin
      errors++;
      $display("FAIL hold_time got %b want %b", bus.seg_export, ZEROS);
    end
    bus.run = 1'b1;
    cyc(7);
    checks++;
    if (bus.tick_1hz !== 1'b0) begin errors++; $display("FAIL hold_resume_early got %b want 0", bus.tick_1hz); end
    cyc(1);
    checks++;
    if (bus.tick_1hz !== 1'b1) begin errors++; $display("FAIL hold_resume_tick got %b want 1", bus.tick_1hz); end
    bus.run = 1'b0;
    pulse_set();
    checks++;
    if (bus.editing !== 1'b1) begin errors++; $display("FAIL hold_set_advance got %b want 1", bus.editing); end
    pulse_set();
    pulse_set();
    pulse_set();
    checks++;
    if (bus.editing !== 1'b0) begin errors++; $display("FAIL hold_set_return got %b want 0", bus.editing); end
    bus.run = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(24);
    pulse_set();
    pulse_inc(5);
    pulse_set();
    pulse_set();
    pulse_inc(1);
    pulse_set();
    cyc(1);
    checks++;
    if (bus.seg_export !== seg6(0, 5, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_clear_sec got %b want %b", bus.seg_export, seg6(0, 5, 0, 0, 0, 0));
    end
    pulse_set();
    pulse_set();
    pulse_set();
    cyc(3);
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.editing !== 1'b0) begin errors++; $display("FAIL mid_reset_editing got %b want 0", bus.editing); end
    checks++;
    if (bus.seg_export !== ZEROS) begin
      errors++;
      $display("FAIL mid_reset_seg got %b want %b", bus.seg_export, ZEROS);
    end
    checks++;
    if (bus.tick_1hz !== 1'b0 || bus.day_wrap !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pulses got %b%b want 00", bus.tick_1hz, bus.day_wrap);
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bus.run     = 1'b1;
    bus.set_req = 1'b0;
    bus.inc     = 1'b0;
    test_reset();
    test_tick();
    test_day_wrap();
    test_set_hours();
    test_set_inc_collide();
    test_run_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
